vga_timing_gen: RTL and testbench

- Raster timing source for the 640x480@60 display path. It produces the x/y pixel coordinates, sync pulses, the active-video flag and the per-frame `next_frame` strobe.
- Every pattern generator consumes these signals.
- It sits between the top-level clock/reset and the pattern mux.
- Horizontal and vertical timing are each tracked by a phase state machine plus a counter, advanced on a pixel-clock enable.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_timing_gen_if.sv | 37 +++
 rtl/vga_phase_counter.sv | 68 ++++++
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants, phase encoding and sync helper for the 640x480@60 raster path.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam logic DEF_SYNC_POL = 1'b0;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    function automatic logic syncLevel(input logic inSync, input logic pol);
        return inSync ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and pattern generators (slave).
// frame_count is present only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic             pix_en;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             hsync;
    logic             vsync;
    logic             display_on;
    logic             next_frame;
`ifdef VGA_FRAME_COUNT_EN
    logic [CNT_W-1:0] frame_count;

    modport master (
        input  pix_en,
        output x, y, hsync, vsync, display_on, next_frame, frame_count
    );

    modport slave (
        output pix_en,
        input  x, y, hsync, vsync, display_on, next_frame, frame_count
    );
`else
    modport master (
        input  pix_en,
        output x, y, hsync, vsync, display_on, next_frame
    );

    modport slave (
        output pix_en,
        input  x, y, hsync, vsync, display_on, next_frame
    );
`endif

endinterface

// File: rtl/vga_phase_counter.sv
// One raster axis: a position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM, stepped by i_adv.
// o_wrap is combinational so the next axis can step on the same edge that returns count to 0.
module vga_phase_counter
    import vga_timing_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_adv,
    input  logic [W-1:0] i_len_active,
    input  logic [W-1:0] i_len_front,
    input  logic [W-1:0] i_len_sync,
    input  logic [W-1:0] i_len_back,
    output logic [W-1:0] o_count,
    output phase_t       o_phase,
    output logic         o_wrap
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_countNxt;
    phase_t       r_phase;
    phase_t       w_phaseNxt;

    // Phase end positions held one bit wider so a 1024-long axis still compares correctly.
    logic [W:0] w_endActive;
    logic [W:0] w_endFront;
    logic [W:0] w_endSync;
    logic [W:0] w_endBack;
    logic [W:0] w_countP1;
    logic       w_atEnd;

    assign w_endActive = {1'b0, i_len_active};
    assign w_endFront  = w_endActive + {1'b0, i_len_front};
    assign w_endSync   = w_endFront + {1'b0, i_len_sync};
    assign w_endBack   = w_endSync + {1'b0, i_len_back};
    assign w_countP1   = {1'b0, r_count} + (W+1)'(1);
    assign w_atEnd     = (w_countP1 == w_endBack);

    assign o_wrap  = i_adv & w_atEnd;
    assign o_count = r_count;
    assign o_phase = r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_phase <= ACTIVE;
        end else begin
            r_count <= w_countNxt;
            r_phase <= w_phaseNxt;
        end
    end

    always_comb begin
        w_countNxt = r_count;
        w_phaseNxt = r_phase;
        if (i_adv) begin
            w_countNxt = w_atEnd ? '0 : w_countP1[W-1:0];
            unique case (r_phase)
                ACTIVE: if (w_countP1 == w_endActive) w_phaseNxt = FRONT;
                FRONT:  if (w_countP1 == w_endFront)  w_phaseNxt = SYNC;
                SYNC:   if (w_countP1 == w_endSync)   w_phaseNxt = BACK;
                BACK:   if (w_atEnd)                  w_phaseNxt = ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing source: x/y, syncs, display_on and the per-frame next_frame strobe.
// Define VGA_FRAME_COUNT_EN to add the 10-bit frame_count output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master io_vga
);

    localparam logic [CNT_W-1:0] L_H_ACTIVE = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] L_H_FRONT  = CNT_W'(H_FRONT);
    localparam logic [CNT_W-1:0] L_H_SYNC   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] L_H_BACK   = CNT_W'(H_BACK);
    localparam logic [CNT_W-1:0] L_V_ACTIVE = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] L_V_FRONT  = CNT_W'(V_FRONT);
    localparam logic [CNT_W-1:0] L_V_SYNC   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] L_V_BACK   = CNT_W'(V_BACK);

    logic [CNT_W-1:0] w_hCount;
    logic [CNT_W-1:0] w_vCount;
    phase_t           w_hPhase;
    phase_t           w_vPhase;
    logic             w_hWrap;
    logic             w_vWrap;
    logic             w_vAdv;
    logic             r_nextFrame;

    assign w_vAdv = io_vga.pix_en & w_hWrap;

    vga_phase_counter #(.W(CNT_W)) u_hCounter (
        .clk          (clk),
        .rst          (rst),
        .i_adv        (io_vga.pix_en),
        .i_len_active (L_H_ACTIVE),
        .i_len_front  (L_H_FRONT),
        .i_len_sync   (L_H_SYNC),
        .i_len_back   (L_H_BACK),
        .o_count      (w_hCount),
        .o_phase      (w_hPhase),
        .o_wrap       (w_hWrap)
    );

    vga_phase_counter #(.W(CNT_W)) u_vCounter (
        .clk          (clk),
        .rst          (rst),
        .i_adv        (w_vAdv),
        .i_len_active (L_V_ACTIVE),
        .i_len_front  (L_V_FRONT),
        .i_len_sync   (L_V_SYNC),
        .i_len_back   (L_V_BACK),
        .o_count      (w_vCount),
        .o_phase      (w_vPhase),
        .o_wrap       (w_vWrap)
    );

    // The vertical wrap already includes pix_en, so a stall right after the wrap cannot stretch the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nextFrame <= 1'b0;
        end else begin
            r_nextFrame <= w_vWrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [CNT_W-1:0] r_frameCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frameCount <= '0;
        end else if (w_vWrap) begin
            r_frameCount <= r_frameCount + CNT_W'(1);
        end
    end

    assign io_vga.frame_count = r_frameCount;
`endif

    // Sync and blanking decode only from the phase registers, never from pix_en.
    assign io_vga.x          = w_hCount;
    assign io_vga.y          = w_vCount;
    assign io_vga.hsync      = syncLevel(w_hPhase == SYNC, SYNC_POL);
    assign io_vga.vsync      = syncLevel(w_vPhase == SYNC, SYNC_POL);
    assign io_vga.display_on = (w_hPhase == ACTIVE) && (w_vPhase == ACTIVE);
    assign io_vga.next_frame = r_nextFrame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 640x480 instance and a tiny SYNC_POL=1 instance checked against a coordinate model.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int S_HA = 8;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 2;
    localparam int S_VA = 4;
    localparam int S_VF = 1;
    localparam int S_VS = 2;
    localparam int S_VB = 1;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       de;
        logic       nf;
        logic [9:0] fc;
    } expT;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    int passCount  = 0;
    int checkCount = 0;
    int cyc        = 0;

    int hLowCnt0, deCnt0, vHighCnt1, hHighCnt1, nfCnt1, lastNfCyc1, nfPeriod1;

    vga_timing_gen_if if0 ();
    vga_timing_gen_if if1 ();

    vga_timing_gen dut0 (
        .clk    (clk),
        .rst    (rst0),
        .io_vga (if0)
    );

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_ACTIVE (S_VA), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .SYNC_POL (1'b1)
    ) dut1 (
        .clk    (clk),
        .rst    (rst1),
        .io_vga (if1)
    );

    always #5 clk = ~clk;

    int   hA[2] = '{DEF_H_ACTIVE, S_HA};
    int   hF[2] = '{DEF_H_FRONT,  S_HF};
    int   hS[2] = '{DEF_H_SYNC,   S_HS};
    int   hB[2] = '{DEF_H_BACK,   S_HB};
    int   vA[2] = '{DEF_V_ACTIVE, S_VA};
    int   vF[2] = '{DEF_V_FRONT,  S_VF};
    int   vS[2] = '{DEF_V_SYNC,   S_VS};
    int   vB[2] = '{DEF_V_BACK,   S_VB};
    logic pol[2] = '{1'b0, 1'b1};

    int   mX[2];
    int   mY[2];
    int   mFc[2];
    logic mNf[2];

    expT sbQ0[$];
    expT sbQ1[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference model works on plain x/y integers; phases are implied by coordinate ranges.
    task automatic modelStep(input int d, input logic en, input logic rs);
        int hTot;
        int vTot;
        hTot = hA[d] + hF[d] + hS[d] + hB[d];
        vTot = vA[d] + vF[d] + vS[d] + vB[d];
        if (rs) begin
            mX[d] = 0; mY[d] = 0; mFc[d] = 0; mNf[d] = 1'b0;
        end else if (en) begin
            mNf[d] = (mX[d] == hTot - 1) && (mY[d] == vTot - 1);
            if (mX[d] == hTot - 1) begin
                mX[d] = 0;
                mY[d] = (mY[d] == vTot - 1) ? 0 : mY[d] + 1;
            end else begin
                mX[d] = mX[d] + 1;
            end
            if (mNf[d]) mFc[d] = (mFc[d] + 1) % 1024;
        end else begin
            mNf[d] = 1'b0;
        end
    endtask

    function automatic expT modelExp(input int d);
        expT e;
        int  hs0;
        int  vs0;
        hs0  = hA[d] + hF[d];
        vs0  = vA[d] + vF[d];
        e.x  = 10'(mX[d]);
        e.y  = 10'(mY[d]);
        e.hs = (mX[d] >= hs0 && mX[d] < hs0 + hS[d]) ? pol[d] : ~pol[d];
        e.vs = (mY[d] >= vs0 && mY[d] < vs0 + vS[d]) ? pol[d] : ~pol[d];
        e.de = (mX[d] < hA[d]) && (mY[d] < vA[d]);
        e.nf = mNf[d];
`ifdef VGA_FRAME_COUNT_EN
        e.fc = 10'(mFc[d]);
`else
        e.fc = '0;
`endif
        return e;
    endfunction

    function automatic expT observe(input int d);
        expT o;
        if (d == 0) begin
            o.x = if0.x; o.y = if0.y; o.hs = if0.hsync; o.vs = if0.vsync;
            o.de = if0.display_on; o.nf = if0.next_frame;
`ifdef VGA_FRAME_COUNT_EN
            o.fc = if0.frame_count;
`else
            o.fc = '0;
`endif
        end else begin
            o.x = if1.x; o.y = if1.y; o.hs = if1.hsync; o.vs = if1.vsync;
            o.de = if1.display_on; o.nf = if1.next_frame;
`ifdef VGA_FRAME_COUNT_EN
            o.fc = if1.frame_count;
`else
            o.fc = '0;
`endif
        end
        return o;
    endfunction

    // Drive one clock of stimulus, queue the model's expectation, then compare after the edge.
    task automatic applyStimulus(input logic en0, input logic en1, input logic r0, input logic r1);
        @(negedge clk);
        if0.pix_en = en0;
        if1.pix_en = en1;
        rst0 = r0;
        rst1 = r1;
        modelStep(0, en0, r0);
        sbQ0.push_back(modelExp(0));
        modelStep(1, en1, r1);
        sbQ1.push_back(modelExp(1));
        @(posedge clk);
        #1;
        cyc++;
        checkOutput("dut0State", observe(0), sbQ0.pop_front());
        checkOutput("dut1State", observe(1), sbQ1.pop_front());
        if (if0.hsync == 1'b0) hLowCnt0++;
        if (if0.display_on)    deCnt0++;
        if (if1.vsync)         vHighCnt1++;
        if (if1.hsync)         hHighCnt1++;
        if (if1.next_frame) begin
            nfCnt1++;
            if (lastNfCyc1 >= 0) nfPeriod1 = cyc - lastNfCyc1;
            lastNfCyc1 = cyc;
        end
    endtask

    task automatic clearStats();
        hLowCnt0 = 0; deCnt0 = 0; vHighCnt1 = 0; hHighCnt1 = 0;
        nfCnt1 = 0; lastNfCyc1 = -1; nfPeriod1 = 0;
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.pix_en = 1'b0;
        if1.pix_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mX[d] = 0; mY[d] = 0; mFc[d] = 0; mNf[d] = 1'b0;
        end
        clearStats();

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("rstX0",     if0.x, 0);
        checkOutput("rstY0",     if0.y, 0);
        checkOutput("rstHsync0", if0.hsync, 1);
        checkOutput("rstVsync0", if0.vsync, 1);
        checkOutput("rstDe0",    if0.display_on, 1);
        checkOutput("rstNf0",    if0.next_frame, 0);
        checkOutput("rstHsync1", if1.hsync, 0);
        checkOutput("rstVsync1", if1.vsync, 0);

        // One full default line; the small instance runs one frame then stalls right after its wrap.
        clearStats();
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'b1, (i < 120) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        end
        checkOutput("hsyncLowWidth", hLowCnt0, 96);
        checkOutput("displayOnLine", deCnt0, 640);
        checkOutput("lineWrapX",     if0.x, 0);
        checkOutput("lineWrapY",     if0.y, 1);
        checkOutput("smallVsyncHi",  vHighCnt1, S_VS * (S_HA + S_HF + S_HS + S_HB));
        checkOutput("smallHsyncHi",  hHighCnt1, S_HS * (S_VA + S_VF + S_VS + S_VB));
        checkOutput("smallNfPulses", nfCnt1, 1);

        // Alternating pix_en doubles the frame period in clocks; three frames from reset.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        clearStats();
        for (int i = 0; i < 720; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        end
        checkOutput("stallNfPulses", nfCnt1, 3);
        checkOutput("stallPeriod",   nfPeriod1, 240);
`ifdef VGA_FRAME_COUNT_EN
        checkOutput("frameCount3",   if1.frame_count, 3);
`endif

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("midRstX",     if0.x, 0);
        checkOutput("midRstY",     if0.y, 0);
        checkOutput("midRstHsync", if0.hsync, 1);
        checkOutput("midRstDe",    if0.display_on, 1);
        checkOutput("midRstNf",    if0.next_frame, 0);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
